// File: rtl/scr1_imem_arb2_if.sv
// One imem-style request/response port: a requester drives req/addr, the
// responder drives req_ack/rdata/resp.
interface scr1_imem_arb2_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              req_ack;
  logic [31:0]       rdata;
  logic [1:0]        resp;

  modport master (output req, addr, input req_ack, rdata, resp);
  modport slave  (input req, addr, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_imem_arb2.sv
// Two-master round-robin arbiter for the SCR1 imem port. Requests lock until
// accepted; an in-order ID FIFO steers each response back to its issuer.
module scr1_imem_arb2 #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned OUTST  = 2,
  localparam int unsigned CntW   = $clog2(OUTST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  scr1_imem_arb2_if.slave      m0_if,
  scr1_imem_arb2_if.slave      m1_if,
  scr1_imem_arb2_if.master     imem_if,
  output logic [CntW-1:0]      outst_cnt,
  output logic                 err_unexp
);

  localparam int unsigned PtrW = (OUTST > 1) ? $clog2(OUTST) : 1;

  logic             lock_q, lock_d;
  logic             lock_own_q, lock_own_d;
  logic             prio_q, prio_d;
  logic [OUTST-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic owner_vld, owner;
  logic full, empty, push, pop, head, resp_vld;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(OUTST - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A locked owner keeps the port regardless of priority until it is acked.
  always_comb begin
    owner_vld = 1'b0;
    owner     = 1'b0;
    if (lock_q) begin
      owner     = lock_own_q;
      owner_vld = lock_own_q ? m1_if.req : m0_if.req;
    end else if (m0_if.req && m1_if.req) begin
      owner_vld = 1'b1;
      owner     = prio_q;
    end else if (m0_if.req) begin
      owner_vld = 1'b1;
    end else if (m1_if.req) begin
      owner_vld = 1'b1;
      owner     = 1'b1;
    end
  end

  assign full     = (cnt_q == CntW'(OUTST));
  assign empty    = (cnt_q == '0);
  assign resp_vld = (imem_if.resp != 2'b00);
  assign head     = fifo_q[rptr_q];

  assign imem_if.req  = owner_vld & ~full;
  assign imem_if.addr = owner_vld ? (owner ? m1_if.addr : m0_if.addr) : '0;

  assign push = imem_if.req & imem_if.req_ack;
  // Pop uses the pre-push head; a same-cycle response to a new request is unexpected.
  assign pop  = resp_vld & ~empty;

  assign m0_if.req_ack = push & ~owner;
  assign m1_if.req_ack = push & owner;
  assign m0_if.rdata   = imem_if.rdata;
  assign m1_if.rdata   = imem_if.rdata;
  assign m0_if.resp    = (pop && !head) ? imem_if.resp : 2'b00;
  assign m1_if.resp    = (pop && head)  ? imem_if.resp : 2'b00;

  assign outst_cnt = cnt_q;
  assign err_unexp = err_q;

  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    prio_d     = prio_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    err_d      = err_q | (resp_vld & empty);

    if (push) begin
      lock_d         = 1'b0;
      prio_d         = ~owner;
      fifo_d[wptr_q] = owner;
      wptr_d         = ptr_inc(wptr_q);
    end else if (imem_if.req) begin
      lock_d     = 1'b1;
      lock_own_d = owner;
    end

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      prio_q     <= 1'b0;
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      prio_q     <= prio_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_scr1_imem_arb2.sv
// Bench for scr1_imem_arb2: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_scr1_imem_arb2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OUTST  = 2;
  localparam int unsigned CntW   = $clog2(OUTST + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [CntW-1:0] outst_cnt;
  logic            err_unexp;
  logic [31:0]     cur_rdata;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  scr1_imem_arb2_if #(.ADDR_W(ADDR_W)) m0_if ();
  scr1_imem_arb2_if #(.ADDR_W(ADDR_W)) m1_if ();
  scr1_imem_arb2_if #(.ADDR_W(ADDR_W)) imem_if ();

  scr1_imem_arb2 #(
    .ADDR_W (ADDR_W),
    .OUTST  (OUTST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_if     (m0_if),
    .m1_if     (m1_if),
    .imem_if   (imem_if),
    .outst_cnt (outst_cnt),
    .err_unexp (err_unexp)
  );

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_a0;
    logic        e_a1;
    logic [1:0]  e_r0;
    logic [1:0]  e_r1;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mkv(input logic rst_v, r0, input logic [31:0] a0, input logic r1,
                               input logic [31:0] a1, input logic ack, input logic [1:0] resp,
                               input logic [31:0] rdata, input logic e_req,
                               input logic [31:0] e_addr, input logic e_a0, e_a1,
                               input logic [1:0] e_r0, e_r1, input logic [3:0] e_cnt);
    vec_t v;
    v.rst = rst_v;  v.r0 = r0;  v.a0 = a0;  v.r1 = r1;  v.a1 = a1;
    v.ack = ack;  v.resp = resp;  v.rdata = rdata;
    v.e_req = e_req;  v.e_addr = e_addr;  v.e_a0 = e_a0;  v.e_a1 = e_a1;
    v.e_r0 = e_r0;  v.e_r1 = e_r1;  v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, r0, input logic [31:0] a0, input logic r1,
                       input logic [31:0] a1, input logic ack, input logic [1:0] resp,
                       input logic [31:0] rdata);
    @(negedge clk);
    rst             = r;
    m0_if.req       = r0;
    m0_if.addr      = a0;
    m1_if.req       = r1;
    m1_if.addr      = a1;
    imem_if.req_ack = ack;
    imem_if.resp    = resp;
    imem_if.rdata   = rdata;
    cur_rdata       = rdata;
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_a0, e_a1, input logic [1:0] e_r0, e_r1,
                           input logic [3:0] e_cnt, input logic e_err);
    chk($sformatf("%s.imem_req", tag), 64'(imem_if.req), 64'(e_req));
    chk($sformatf("%s.imem_addr", tag), 64'(imem_if.addr), 64'(e_addr));
    chk($sformatf("%s.m0_ack", tag), 64'(m0_if.req_ack), 64'(e_a0));
    chk($sformatf("%s.m1_ack", tag), 64'(m1_if.req_ack), 64'(e_a1));
    chk($sformatf("%s.m0_resp", tag), 64'(m0_if.resp), 64'(e_r0));
    chk($sformatf("%s.m1_resp", tag), 64'(m1_if.resp), 64'(e_r1));
    chk($sformatf("%s.m0_rdata", tag), 64'(m0_if.rdata), 64'(cur_rdata));
    chk($sformatf("%s.m1_rdata", tag), 64'(m1_if.rdata), 64'(cur_rdata));
    chk($sformatf("%s.outst_cnt", tag), 64'(outst_cnt), 64'(e_cnt));
    chk($sformatf("%s.err_unexp", tag), 64'(err_unexp), 64'(e_err));
  endtask

  vec_t vq[$];

  // Reference model state
  int   mq[$];
  bit   lk, lk_own, pr, merr;
  bit   rq[2];
  logic [31:0] ad[2];

  initial begin
    rst = 1'b1;
    m0_if.req = 1'b0;  m0_if.addr = '0;
    m1_if.req = 1'b0;  m1_if.addr = '0;
    imem_if.req_ack = 1'b0;  imem_if.resp = 2'b00;  imem_if.rdata = '0;
    cur_rdata = '0;
    repeat (2) @(posedge clk);

    // rst r0 a0 r1 a1 ack resp rdata | req addr ack0 ack1 resp0 resp1 cnt
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 0));
    vq[0].e_req = 1'b0;
    vq.push_back(mkv(0, 1, 'h100, 0, 0, 1, 0, 0,           1, 'h100, 1, 0, 0, 0, 0));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 2'b01, 'h5063,      0, 0, 0, 0, 2'b01, 0, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h200, 1, 'h300, 1, 0, 0,       1, 'h200, 1, 0, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h200, 1, 'h300, 1, 0, 0,       1, 'h300, 0, 1, 0, 0, 1));
    vq.push_back(mkv(0, 1, 'h200, 1, 'h300, 1, 2'b01, 'hA0, 0, 'h200, 0, 0, 2'b01, 0, 2));
    vq.push_back(mkv(0, 1, 'h200, 1, 'h300, 1, 2'b01, 'hA1, 1, 'h200, 1, 0, 0, 2'b01, 1));
    vq.push_back(mkv(0, 1, 'h200, 1, 'h300, 1, 2'b01, 'hA2, 1, 'h300, 0, 1, 2'b01, 0, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 2'b01, 'hA3,        0, 0, 0, 0, 0, 2'b01, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 0, 0, 1, 'h400, 0, 0, 0,           1, 'h400, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h500, 1, 'h400, 0, 0, 0,       1, 'h400, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h500, 1, 'h400, 0, 0, 0,       1, 'h400, 0, 0, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h500, 1, 'h400, 1, 0, 0,       1, 'h400, 0, 1, 0, 0, 0));
    vq.push_back(mkv(0, 1, 'h500, 0, 0, 1, 0, 0,           1, 'h500, 1, 0, 0, 0, 1));
    vq.push_back(mkv(0, 1, 'h600, 0, 0, 1, 0, 0,           0, 'h600, 0, 0, 0, 0, 2));
    vq.push_back(mkv(0, 1, 'h600, 0, 0, 1, 2'b10, 'hBAD,   0, 'h600, 0, 0, 0, 2'b10, 2));
    vq.push_back(mkv(0, 1, 'h600, 0, 0, 1, 0, 0,           1, 'h600, 1, 0, 0, 0, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 2'b01, 'hC1,        0, 0, 0, 0, 2'b01, 0, 2));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 2'b10, 'hC2,        0, 0, 0, 0, 2'b10, 0, 1));
    vq.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].r0, vq[i].a0, vq[i].r1, vq[i].a1, vq[i].ack, vq[i].resp,
            vq[i].rdata);
      check_all($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_a0, vq[i].e_a1,
                vq[i].e_r0, vq[i].e_r1, vq[i].e_cnt, 1'b0);
    end

    // Same-cycle accept and response with empty FIFO: unexpected, push still happens.
    drive(0, 1, 'h700, 0, 0, 1, 2'b01, 'h11);
    check_all("h1", 1, 'h700, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("h2", 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 2'b01, 'h22);
    check_all("h3", 0, 0, 0, 0, 2'b01, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 2'b10, 'h23);
    check_all("h4", 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("h5", 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check_all("h6", 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("h7", 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with one ID in flight and a locked pending request.
    drive(0, 0, 0, 1, 'h800, 1, 0, 0);
    check_all("h8", 1, 'h800, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 'h900, 0, 0, 0, 0, 0);
    check_all("h9", 1, 'h900, 0, 0, 0, 0, 1, 0);
    drive(1, 1, 'h900, 0, 0, 0, 0, 0);
    check_all("h10", 1, 'h900, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 2'b01, 'h33);
    check_all("h11", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("h12", 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check_all("h13", 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    mq.delete();
    lk = 0;  lk_own = 0;  pr = 0;  merr = 0;
    rq[0] = 0;  rq[1] = 0;  ad[0] = '0;  ad[1] = '0;
    for (int c = 0; c < 600; c++) begin
      int         own;
      bit         ov, e_req, ack, a0, a1;
      logic [1:0] resp, r0, r1;
      logic [31:0] e_addr;
      for (int x = 0; x < 2; x++) begin
        if (!rq[x] && $urandom_range(0, 2) == 0) begin
          rq[x] = 1;
          ad[x] = $urandom;
        end
      end
      ack  = ($urandom_range(0, 2) != 0);
      resp = 2'b00;
      if (mq.size() > 0 && $urandom_range(0, 2) == 0) resp = $urandom_range(0, 1) ? 2'b01 : 2'b10;

      own = 0;
      ov  = 0;
      if (lk) begin
        own = int'(lk_own);
        ov  = rq[own];
      end else if (rq[0] && rq[1]) begin
        own = int'(pr);
        ov  = 1;
      end else if (rq[0] || rq[1]) begin
        own = rq[1] ? 1 : 0;
        ov  = 1;
      end
      e_req  = ov && (mq.size() < int'(OUTST));
      e_addr = ov ? ad[own] : '0;
      a0     = ack && e_req && own == 0;
      a1     = ack && e_req && own == 1;
      r0     = (resp != 0 && mq.size() > 0 && mq[0] == 0) ? resp : 2'b00;
      r1     = (resp != 0 && mq.size() > 0 && mq[0] == 1) ? resp : 2'b00;

      drive(0, rq[0], ad[0], rq[1], ad[1], ack, resp, $urandom);
      check_all($sformatf("r%0d", c), e_req, e_addr, a0, a1, r0, r1, 4'(mq.size()), merr);

      if (resp != 0) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else merr = 1;
      end
      if (e_req && ack) begin
        mq.push_back(own);
        pr = (own == 0);
        lk = 0;
        rq[own] = ($urandom_range(0, 1) == 1);
        ad[own] = $urandom;
      end else if (e_req) begin
        lk     = 1;
        lk_own = (own == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
